trap_ctrl: RTL and testbench

- Trap sequencer that drives the CSR file's trap-update interface.
  - Outputs to the CSR file: enter, pc, interrupt, code, value, leave.
  - Inputs from the CSR file: mtvec, mepc, mstatus.MIE, mie, mip.
- Sits at the commit (W) stage. Decides when a committing instruction traps or takes an interrupt, or when an mret retires.
- Then sequences pipeline flush, memory drain, the CSR update pulse and the fetch redirect.

---
 rtl/trap_pkg.sv | 21 ++
 rtl/irq_prio.sv | 39 +++
 rtl/trap_ctrl.sv | 154 +++++++++++++++
 tb/tb_trap_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared constants for the trap sequencer: FSM state encodings and
// the interrupt / exception cause numbers it produces or checks against.
package trap_pkg;

    typedef logic [2:0] trap_state_t;

    localparam trap_state_t ST_IDLE  = 3'd0;
    localparam trap_state_t ST_DRAIN = 3'd1;
    localparam trap_state_t ST_TRAP  = 3'd2;
    localparam trap_state_t ST_RET   = 3'd3;
    localparam trap_state_t ST_REDIR = 3'd4;

    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam int EXC_ILLEGAL     = 2;
    localparam int EXC_LD_MISALIGN = 4;
    localparam int EXC_ECALL_M     = 11;

endpackage

// File: rtl/irq_prio.sv
// Machine-level interrupt priority picker: MEI > MSI > MTI, gated by mstatus.MIE.
module irq_prio
    import trap_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CODE_W = 5
) (
    input  logic              mstatus_mie,
    input  logic [XLEN-1:0]   mie,
    input  logic [XLEN-1:0]   mip,
    output logic              pend,
    output logic [CODE_W-1:0] code
);

    logic [XLEN-1:0] active;
    logic            mei, msi, mti;
    logic            unused_bits;

    assign active = mie & mip;
    assign mei    = mstatus_mie & active[IRQ_MEI];
    assign msi    = mstatus_mie & active[IRQ_MSI];
    assign mti    = mstatus_mie & active[IRQ_MTI];

    // Only the three machine-level sources are implemented.
    assign unused_bits = ^active;

    always_comb begin
        pend = mei | msi | mti;
        code = '0;
        if (mei) begin
            code = CODE_W'(IRQ_MEI);
        end else if (msi) begin
            code = CODE_W'(IRQ_MSI);
        end else if (mti) begin
            code = CODE_W'(IRQ_MTI);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Commit-stage trap sequencer: flush, memory drain, CSR trap/mret pulse, fetch redirect.
// Build option: define VECTORED_MTVEC_EN to honour mtvec vectored mode for interrupts.
//
// state | meaning
// IDLE  | watching commits for interrupt / exception / mret
// DRAIN | pipeline flushed and stalled, waiting for data memory to go idle
// TRAP  | one-cycle csr_enter with latched pc/cause/value
// RET   | one-cycle csr_leave plus redirect to mepc
// REDIR | redirect fetch to the trap vector, release stall
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CODE_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic              commit_exc,
    input  logic [CODE_W-1:0] commit_code,
    input  logic [XLEN-1:0]   commit_tval,
    input  logic              commit_mret,
    input  logic              mstatus_mie,
    input  logic [XLEN-1:0]   mie_i,
    input  logic [XLEN-1:0]   mip_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    input  logic              mem_busy,
    output logic              commit_kill,
    output logic              flush,
    output logic              stall,
    output logic              csr_enter,
    output logic [XLEN-1:0]   csr_pc,
    output logic              csr_interrupt,
    output logic [62:0]       csr_code,
    output logic [XLEN-1:0]   csr_value,
    output logic              csr_leave,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    trap_state_t       state_q, state_d;
    logic              irq_pend;
    logic [CODE_W-1:0] irq_code;
    logic              in_idle;
    logic              take_irq, take_exc, take_mret;
    logic [XLEN-1:0]   pc_q, value_q;
    logic [CODE_W-1:0] code_q;
    logic              irq_q;
    logic [XLEN-1:0]   tvec_base, tvec_target;

    irq_prio #(
        .XLEN   (XLEN),
        .CODE_W (CODE_W)
    ) u_irq_prio (
        .mstatus_mie (mstatus_mie),
        .mie         (mie_i),
        .mip         (mip_i),
        .pend        (irq_pend),
        .code        (irq_code)
    );

    // Interrupt beats exception, exception beats mret.
    assign in_idle   = (state_q == ST_IDLE);
    assign take_irq  = in_idle & commit_valid & irq_pend;
    assign take_exc  = in_idle & commit_valid & ~irq_pend & commit_exc;
    assign take_mret = in_idle & commit_valid & ~irq_pend & ~commit_exc & commit_mret;

    assign commit_kill = take_irq | take_exc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_irq || take_exc) begin
                    state_d = ST_DRAIN;
                end else if (take_mret) begin
                    state_d = ST_RET;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy) begin
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP:  state_d = ST_REDIR;
            ST_RET:   state_d = ST_IDLE;
            ST_REDIR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pc_q           <= '0;
            code_q         <= '0;
            value_q        <= '0;
            irq_q          <= 1'b0;
            flush          <= 1'b0;
            stall          <= 1'b0;
            csr_enter      <= 1'b0;
            csr_leave      <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush          <= (state_d == ST_DRAIN) || (state_d == ST_RET);
            stall          <= (state_d == ST_DRAIN) || (state_d == ST_TRAP);
            csr_enter      <= (state_d == ST_TRAP);
            csr_leave      <= (state_d == ST_RET);
            redirect_valid <= (state_d == ST_REDIR) || (state_d == ST_RET);
            if (take_irq) begin
                pc_q    <= commit_pc;
                irq_q   <= 1'b1;
                code_q  <= irq_code;
                value_q <= '0;
            end else if (take_exc) begin
                pc_q    <= commit_pc;
                irq_q   <= 1'b0;
                code_q  <= commit_code;
                value_q <= commit_tval;
            end
        end
    end

    assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
    assign tvec_target = ((mtvec_i[1:0] == 2'b01) && irq_q)
                       ? tvec_base + (XLEN'(code_q) << 2)
                       : tvec_base;
`else
    logic unused_mode;
    assign unused_mode = ^mtvec_i[1:0];
    assign tvec_target = tvec_base;
`endif

    // mepc is sampled in RET, before the CSR file applies the mret update.
    always_comb begin
        redirect_pc = '0;
        if (state_q == ST_REDIR) begin
            redirect_pc = tvec_target;
        end else if (state_q == ST_RET) begin
            redirect_pc = mepc_i;
        end
    end

    assign csr_pc        = pc_q;
    assign csr_interrupt = irq_q;
    assign csr_code      = 63'(code_q);
    assign csr_value     = value_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected events with their
// cycle numbers, a negedge monitor pops and compares whenever the DUT emits one.
module tb_trap_ctrl;

    localparam int XLEN   = 64;
    localparam int CODE_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              commit_valid;
    logic [XLEN-1:0]   commit_pc;
    logic              commit_exc;
    logic [CODE_W-1:0] commit_code;
    logic [XLEN-1:0]   commit_tval;
    logic              commit_mret;
    logic              mstatus_mie;
    logic [XLEN-1:0]   mie_i, mip_i, mtvec_i, mepc_i;
    logic              mem_busy;
    logic              commit_kill, flush, stall, csr_enter, csr_interrupt;
    logic              csr_leave, redirect_valid;
    logic [XLEN-1:0]   csr_pc, csr_value, redirect_pc;
    logic [62:0]       csr_code;

    trap_ctrl #(.XLEN(XLEN), .CODE_W(CODE_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_exc     (commit_exc),
        .commit_code    (commit_code),
        .commit_tval    (commit_tval),
        .commit_mret    (commit_mret),
        .mstatus_mie    (mstatus_mie),
        .mie_i          (mie_i),
        .mip_i          (mip_i),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .mem_busy       (mem_busy),
        .commit_kill    (commit_kill),
        .flush          (flush),
        .stall          (stall),
        .csr_enter      (csr_enter),
        .csr_pc         (csr_pc),
        .csr_interrupt  (csr_interrupt),
        .csr_code       (csr_code),
        .csr_value      (csr_value),
        .csr_leave      (csr_leave),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_KILL = 0, EV_ENTER = 1, EV_LEAVE = 2, EV_REDIR = 3} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [63:0] pc;
        logic        irq;
        logic [62:0] code;
        logic [63:0] value;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input ev_kind_t k, input string nm, input logic [63:0] pc,
                            input logic irq, input logic [62:0] code, input logic [63:0] val);
        ev_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event at cycle %0d, none queued", nm, cyc);
            return;
        end
        e = q.pop_front();
        if (e.kind != k || e.cyc != cyc || e.pc !== pc || e.irq !== irq ||
            e.code !== code || e.value !== val) begin
            bad++;
            $display("FAIL %s: got cyc=%0d pc=%h irq=%b code=%0d val=%h want kind=%0d cyc=%0d pc=%h irq=%b code=%0d val=%h",
                     nm, cyc, pc, irq, code, val, int'(e.kind), e.cyc, e.pc, e.irq, e.code, e.value);
        end
    endtask

    // Monitor: one scoreboard pop per output event, in a fixed per-cycle order.
    always @(negedge clk) begin
        if (commit_kill)    check_ev(EV_KILL,  "kill",     64'h0, 1'b0, 63'h0, 64'h0);
        if (csr_enter)      check_ev(EV_ENTER, "enter",    csr_pc, csr_interrupt, csr_code, csr_value);
        if (csr_leave)      check_ev(EV_LEAVE, "leave",    64'h0, 1'b0, 63'h0, 64'h0);
        if (redirect_valid) check_ev(EV_REDIR, "redirect", redirect_pc, 1'b0, 63'h0, 64'h0);
    end

    task automatic clear_commit();
        commit_valid = 1'b0;
        commit_exc   = 1'b0;
        commit_mret  = 1'b0;
        commit_code  = '0;
        commit_tval  = '0;
        commit_pc    = '0;
    endtask

    task automatic drive_commit(input logic [63:0] pc, input logic exc, input logic [4:0] code,
                                input logic [63:0] tval, input logic mret);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_exc   = exc;
        commit_code  = code;
        commit_tval  = tval;
        commit_mret  = mret;
    endtask

    task automatic run_trap(input string nm, input logic [63:0] pc, input logic exc,
                            input logic [4:0] code, input logic [63:0] tval, input logic mret,
                            input int busy, input logic exp_irq, input logic [4:0] exp_code,
                            input logic [63:0] exp_val, input logic [63:0] exp_tgt);
        int n;
        @(posedge clk); #1;
        drive_commit(pc, exc, code, tval, mret);
        n = cyc;
        q.push_back('{EV_KILL,  n,            64'h0,   1'b0,    63'h0,         64'h0});
        q.push_back('{EV_ENTER, n + 2 + busy, pc,      exp_irq, 63'(exp_code), exp_val});
        q.push_back('{EV_REDIR, n + 3 + busy, exp_tgt, 1'b0,    63'h0,         64'h0});
        @(posedge clk); #1;
        clear_commit();
        mem_busy = (busy > 0);
        for (int i = 0; i < busy; i++) begin
            check_val({nm, "_drain_stall"}, 64'(stall), 64'h1);
            check_val({nm, "_drain_flush"}, 64'(flush), 64'h1);
            @(posedge clk); #1;
        end
        mem_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val({nm, "_queue_drained"}, 64'(q.size()), 64'h0);
    endtask

    task automatic run_none(input string nm, input logic [63:0] pc);
        @(posedge clk); #1;
        drive_commit(pc, 1'b0, 5'd0, 64'h0, 1'b0);
        check_val({nm, "_no_kill"}, 64'(commit_kill), 64'h0);
        @(posedge clk); #1;
        clear_commit();
        check_val({nm, "_no_stall"}, 64'(stall), 64'h0);
        repeat (4) @(posedge clk);
        #1;
        check_val({nm, "_queue_drained"}, 64'(q.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [63:0] vec_tgt;
        reset       = 1'b1;
        clear_commit();
        mstatus_mie = 1'b0;
        mie_i       = '0;
        mip_i       = '0;
        mtvec_i     = 64'h8000_0100;
        mepc_i      = '0;
        mem_busy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_stall",    64'(stall),          64'h0);
        check_val("rst_flush",    64'(flush),          64'h0);
        check_val("rst_enter",    64'(csr_enter),      64'h0);
        check_val("rst_leave",    64'(csr_leave),      64'h0);
        check_val("rst_redir_v",  64'(redirect_valid), 64'h0);
        check_val("rst_redir_pc", redirect_pc,         64'h0);
        check_val("rst_pc",       csr_pc,              64'h0);
        check_val("rst_code",     64'(csr_code),       64'h0);
        check_val("rst_value",    csr_value,           64'h0);
        check_val("rst_irq",      64'(csr_interrupt),  64'h0);
        reset = 1'b0;

        run_trap("illegal", 64'h8000_0010, 1'b1, 5'd2, 64'h13, 1'b0, 0,
                 1'b0, 5'd2, 64'h13, 64'h8000_0100);
        run_trap("illegal_drain", 64'h8000_0010, 1'b1, 5'd2, 64'h13, 1'b0, 3,
                 1'b0, 5'd2, 64'h13, 64'h8000_0100);
        run_trap("ld_misalign", 64'h8000_0034, 1'b1, 5'd4, 64'h8000_2003, 1'b0, 1,
                 1'b0, 5'd4, 64'h8000_2003, 64'h8000_0100);

        mstatus_mie = 1'b1; mie_i = 64'h888; mip_i = 64'h888;
        run_trap("irq_mei", 64'h8000_0020, 1'b0, 5'd0, 64'hdead, 1'b0, 0,
                 1'b1, 5'd11, 64'h0, 64'h8000_0100);

        mstatus_mie = 1'b0;
        run_none("irq_masked_mie", 64'h8000_0024);

        mstatus_mie = 1'b1; mie_i = 64'h88; mip_i = 64'h88;
        run_trap("irq_msi_over_mti", 64'h8000_0028, 1'b0, 5'd0, 64'h0, 1'b0, 0,
                 1'b1, 5'd3, 64'h0, 64'h8000_0100);

        mie_i = 64'h80; mip_i = 64'h880;
        run_trap("irq_mti_beats_exc", 64'h8000_002c, 1'b1, 5'd2, 64'h77, 1'b0, 0,
                 1'b1, 5'd7, 64'h0, 64'h8000_0100);
        mip_i = '0; mie_i = '0;

        run_none("plain_commit", 64'h8000_0030);

        // mret: leave and redirect one cycle after commit, never killed
        mepc_i = 64'h8000_0040;
        @(posedge clk); #1;
        drive_commit(64'h8000_0038, 1'b0, 5'd0, 64'h0, 1'b1);
        n = cyc;
        q.push_back('{EV_LEAVE, n + 1, 64'h0,          1'b0, 63'h0, 64'h0});
        q.push_back('{EV_REDIR, n + 1, 64'h8000_0040,  1'b0, 63'h0, 64'h0});
        @(posedge clk); #1;
        clear_commit();
        check_val("mret_flush", 64'(flush), 64'h1);
        check_val("mret_stall", 64'(stall), 64'h0);
        repeat (4) @(posedge clk);
        #1;
        check_val("mret_queue_drained", 64'(q.size()), 64'h0);

        run_trap("ecall_with_mret", 64'h8000_0044, 1'b1, 5'd11, 64'h0, 1'b1, 0,
                 1'b0, 5'd11, 64'h0, 64'h8000_0100);

        mtvec_i = 64'h8000_0101;
`ifdef VECTORED_MTVEC_EN
        vec_tgt = 64'h8000_011C;
`else
        vec_tgt = 64'h8000_0100;
`endif
        mie_i = 64'h80; mip_i = 64'h80;
        run_trap("vectored_mti", 64'h8000_0048, 1'b0, 5'd0, 64'h0, 1'b0, 0,
                 1'b1, 5'd7, 64'h0, vec_tgt);
        mie_i = '0; mip_i = '0;
        run_trap("vectored_exc_base", 64'h8000_004c, 1'b1, 5'd2, 64'h5, 1'b0, 0,
                 1'b0, 5'd2, 64'h5, 64'h8000_0100);
        mtvec_i = 64'h8000_0100;

        // reset during drain: kill only, then no csr_enter ever
        @(posedge clk); #1;
        drive_commit(64'h8000_0050, 1'b1, 5'd2, 64'h99, 1'b0);
        n = cyc;
        q.push_back('{EV_KILL, n, 64'h0, 1'b0, 63'h0, 64'h0});
        @(posedge clk); #1;
        clear_commit();
        mem_busy = 1'b1;
        check_val("rstdrain_stall_before", 64'(stall), 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        mem_busy = 1'b0;
        check_val("rstdrain_stall", 64'(stall),    64'h0);
        check_val("rstdrain_flush", 64'(flush),    64'h0);
        check_val("rstdrain_pc",    csr_pc,        64'h0);
        check_val("rstdrain_code",  64'(csr_code), 64'h0);
        check_val("rstdrain_value", csr_value,     64'h0);
        repeat (6) @(posedge clk);
        #1;
        check_val("rstdrain_queue_drained", 64'(q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
